handshake_rx: RTL and testbench

HANDSHAKE_RX -- requirements
Module: handshake_rx

---
 rtl/handshake_rx_pkg.sv | 16 +
 rtl/handshake_rx_sync_line.sv | 28 ++
 rtl/handshake_rx.sv | 94 +++++++++
 tb/tb_handshake_rx.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/handshake_rx_pkg.sv
// handshake_rx_pkg
//   Shared definitions for the handshake_rx block: the 2-bit FSM state
//   encodings and the state enum built on top of them.
package handshake_rx_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    HOLD = ST_HOLD,
    ACK  = ST_ACK
  } state_t;

endpackage

// File: rtl/handshake_rx_sync_line.sv
// handshake_rx_sync_line (the SyncLine synchronizer)
//   Plain STAGES-deep flop chain for bringing asynchronous signals into
//   the CLK domain. The flops are deliberately not reset.
//   Ports:
//     CLK  in           destination clock
//     D    in  [WIDTH]  asynchronous input
//     Q    out [WIDTH]  synchronized output (STAGES edges of latency)
module handshake_rx_sync_line #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             CLK,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] stage_reg [STAGES];

  always_ff @(posedge CLK) begin
    stage_reg[0] <= D;
    for (int i = 1; i < STAGES; i++) begin
      stage_reg[i] <= stage_reg[i-1];
    end
  end

  assign Q = stage_reg[STAGES-1];

endmodule

// File: rtl/handshake_rx.sv
// handshake_rx
//   Receive side of a 4-phase request/acknowledge crossing. REQ_IN is
//   synchronized, the payload is captured into OUT_DATA and presented with
//   a valid/ready interface; ACK_OUT is raised once downstream accepts and
//   released when the synchronized request drops.
//   Ports:
//     CLK        in            destination clock, rising edge
//     RESETn     in            asynchronous active-low reset
//     REQ_IN     in            4-phase request (asynchronous)
//     DATA_IN    in  [WIDTH]   payload, stable while REQ_IN is high
//     ACK_OUT    out           4-phase acknowledge (flop output)
//     OUT_VALID  out           OUT_DATA holds an unaccepted payload
//     OUT_DATA   out [WIDTH]   captured payload
//     OUT_READY  in            downstream accepts when OUT_VALID is high
//     BUSY       out           FSM is not in IDLE
module handshake_rx
  import handshake_rx_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             REQ_IN,
  input  logic [WIDTH-1:0] DATA_IN,
  output logic             ACK_OUT,
  output logic             OUT_VALID,
  output logic [WIDTH-1:0] OUT_DATA,
  input  logic             OUT_READY,
  output logic             BUSY
);

  state_t           state_reg;
  logic             ack_reg;
  logic             valid_reg;
  logic [WIDTH-1:0] data_reg;
  logic             req_s;

  // The synchronizer is the only consumer of REQ_IN.
  handshake_rx_sync_line #(
    .WIDTH  (1),
    .STAGES (STAGES)
  ) u_req_sync (
    .CLK (CLK),
    .D   (REQ_IN),
    .Q   (req_s)
  );

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_reg <= IDLE;
      ack_reg   <= 1'b0;
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_s) begin
            data_reg  <= DATA_IN;
            valid_reg <= 1'b1;
            state_reg <= HOLD;
          end
        end
        HOLD: begin
          // An early-dropped request is ignored here: the acknowledge is
          // still raised for at least one cycle once downstream accepts.
          if (OUT_READY) begin
            valid_reg <= 1'b0;
            ack_reg   <= 1'b1;
            state_reg <= ACK;
          end
        end
        ACK: begin
          if (!req_s) begin
            ack_reg   <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          ack_reg   <= 1'b0;
          valid_reg <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign ACK_OUT   = ack_reg;
  assign OUT_VALID = valid_reg;
  assign OUT_DATA  = data_reg;
  // Decoded from the state flop only; no input reaches this output.
  assign BUSY      = (state_reg != IDLE);

endmodule

// File: tb/tb_handshake_rx.sv
module tb_handshake_rx;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic        REQ_IN;
  logic [31:0] DATA_IN;
  logic        ACK_OUT;
  logic        OUT_VALID;
  logic [31:0] OUT_DATA;
  logic        OUT_READY;
  logic        BUSY;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] rx_q[$];
  logic        ack_chk_en = 1'b1;

  handshake_rx #(.WIDTH(32), .STAGES(2)) dut (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .REQ_IN    (REQ_IN),
    .DATA_IN   (DATA_IN),
    .ACK_OUT   (ACK_OUT),
    .OUT_VALID (OUT_VALID),
    .OUT_DATA  (OUT_DATA),
    .OUT_READY (OUT_READY),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Monitor on the falling edge: records accepted payloads and checks that
  // OUT_DATA is stable while valid and that ACK_OUT only rises under a high
  // request.
  logic        prev_valid = 1'b0;
  logic [31:0] prev_data  = '0;
  logic        prev_ack   = 1'b0;
  logic        prev_req   = 1'b0;
  always @(negedge CLK) begin
    if (RESETn === 1'b1 && OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
      rx_q.push_back(OUT_DATA);
      $display("rx handshake data=0x%08h", OUT_DATA);
    end
    if (prev_valid && OUT_VALID === 1'b1)
      chk("data_stable", {32'd0, OUT_DATA}, {32'd0, prev_data});
    if (ack_chk_en && !prev_ack && ACK_OUT === 1'b1)
      chk("ack_rise_req_high", {63'd0, prev_req}, 64'd1);
    prev_valid = (OUT_VALID === 1'b1);
    prev_data  = OUT_DATA;
    prev_ack   = (ACK_OUT === 1'b1);
    prev_req   = REQ_IN;
  end

  // Clean 4-phase transfer with OUT_READY held high.
  task automatic xfer(input logic [31:0] d);
    DATA_IN = d; REQ_IN = 1'b1; exp_q.push_back(d);
    tick(); chk("xfer_valid_k", {63'd0, OUT_VALID}, 64'd0);
    tick(); chk("xfer_valid_k1", {63'd0, OUT_VALID}, 64'd0);
    tick(); chk("xfer_valid_k2", {63'd0, OUT_VALID}, 64'd1);
    chk("xfer_data", {32'd0, OUT_DATA}, {32'd0, d});
    chk("xfer_busy", {63'd0, BUSY}, 64'd1);
    tick(); chk("xfer_valid_drop", {63'd0, OUT_VALID}, 64'd0);
    chk("xfer_ack_rise", {63'd0, ACK_OUT}, 64'd1);
    REQ_IN = 1'b0; DATA_IN = ~d;
    tick(); chk("xfer_ack_hold1", {63'd0, ACK_OUT}, 64'd1);
    tick(); chk("xfer_ack_hold2", {63'd0, ACK_OUT}, 64'd1);
    chk("xfer_no_capture_in_ack", {32'd0, OUT_DATA}, {32'd0, d});
    tick(); chk("xfer_ack_fall", {63'd0, ACK_OUT}, 64'd0);
    chk("xfer_idle", {63'd0, BUSY}, 64'd0);
    chk("xfer_data_kept", {32'd0, OUT_DATA}, {32'd0, d});
    $display("xfer data=0x%08h done", d);
  endtask

  task automatic wait_ack(input logic lvl);
    int n = 0;
    while (ACK_OUT !== lvl && n < 100) begin
      OUT_READY = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    chk("ack_wait", {63'd0, ACK_OUT}, {63'd0, lvl});
  endtask

  initial begin
    RESETn = 1'b0; REQ_IN = 1'b0; DATA_IN = '0; OUT_READY = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_valid", {63'd0, OUT_VALID}, 64'd0);
    chk("rst_ack", {63'd0, ACK_OUT}, 64'd0);
    chk("rst_data", {32'd0, OUT_DATA}, 64'd0);
    chk("rst_busy", {63'd0, BUSY}, 64'd0);
    RESETn = 1'b1;
    repeat (2) tick();
    $display("reset state checked");

    // Basic transfer, ready always high
    OUT_READY = 1'b1;
    xfer(32'hDEADBEEF);

    // Downstream stalls for 10 cycles
    OUT_READY = 1'b0; DATA_IN = 32'h12345678; REQ_IN = 1'b1;
    exp_q.push_back(32'h12345678);
    repeat (3) tick();
    chk("stall_valid", {63'd0, OUT_VALID}, 64'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_valid_hold", {63'd0, OUT_VALID}, 64'd1);
      chk("stall_data_hold", {32'd0, OUT_DATA}, 64'h12345678);
      chk("stall_ack_low", {63'd0, ACK_OUT}, 64'd0);
    end
    OUT_READY = 1'b1;
    tick();
    chk("stall_valid_drop", {63'd0, OUT_VALID}, 64'd0);
    chk("stall_ack_rise", {63'd0, ACK_OUT}, 64'd1);
    REQ_IN = 1'b0; OUT_READY = 1'b0;
    repeat (3) tick();
    chk("stall_ack_fall", {63'd0, ACK_OUT}, 64'd0);
    chk("stall_data_kept", {32'd0, OUT_DATA}, 64'h12345678);
    $display("stall transfer done");

    // Back-to-back transfers
    OUT_READY = 1'b1;
    xfer(32'h1);
    xfer(32'h2);

    // Reset during HOLD
    OUT_READY = 1'b0; DATA_IN = 32'hA5A5A5A5; REQ_IN = 1'b1;
    repeat (3) tick();
    chk("hold_valid", {63'd0, OUT_VALID}, 64'd1);
    chk("hold_data", {32'd0, OUT_DATA}, 64'hA5A5A5A5);
    #2 RESETn = 1'b0;
    #1;
    chk("async_rst_valid", {63'd0, OUT_VALID}, 64'd0);
    chk("async_rst_data", {32'd0, OUT_DATA}, 64'd0);
    chk("async_rst_ack", {63'd0, ACK_OUT}, 64'd0);
    chk("async_rst_busy", {63'd0, BUSY}, 64'd0);
    REQ_IN = 1'b0;
    repeat (3) tick();
    RESETn = 1'b1;
    repeat (3) tick();
    chk("post_rst_valid", {63'd0, OUT_VALID}, 64'd0);
    chk("post_rst_ack", {63'd0, ACK_OUT}, 64'd0);
    chk("post_rst_busy", {63'd0, BUSY}, 64'd0);
    $display("reset during hold done");

    // One-cycle request pulse
    ack_chk_en = 1'b0;
    OUT_READY = 1'b0; DATA_IN = 32'hCAFEF00D; REQ_IN = 1'b1;
    exp_q.push_back(32'hCAFEF00D);
    tick(); REQ_IN = 1'b0;
    tick(); chk("pulse_valid_early", {63'd0, OUT_VALID}, 64'd0);
    tick(); chk("pulse_valid", {63'd0, OUT_VALID}, 64'd1);
    chk("pulse_data", {32'd0, OUT_DATA}, 64'hCAFEF00D);
    repeat (2) tick();
    chk("pulse_hold", {63'd0, BUSY}, 64'd1);
    OUT_READY = 1'b1;
    tick(); chk("pulse_ack_rise", {63'd0, ACK_OUT}, 64'd1);
    chk("pulse_valid_drop", {63'd0, OUT_VALID}, 64'd0);
    OUT_READY = 1'b0;
    tick(); chk("pulse_ack_fall", {63'd0, ACK_OUT}, 64'd0);
    chk("pulse_idle", {63'd0, BUSY}, 64'd0);
    tick(); chk("pulse_quiet", {63'd0, ACK_OUT | OUT_VALID}, 64'd0);
    ack_chk_en = 1'b1;
    $display("pulse transfer done");

    // Random request/ready timing
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] d;
      d = $urandom;
      DATA_IN = d; REQ_IN = 1'b1; exp_q.push_back(d);
      wait_ack(1'b1);
      repeat ($urandom_range(0, 2)) tick();
      REQ_IN = 1'b0; DATA_IN = $urandom;
      wait_ack(1'b0);
      repeat ($urandom_range(0, 2)) tick();
    end
    OUT_READY = 1'b0;
    repeat (3) tick();

    // Scoreboard: every payload delivered exactly once, in order
    chk("rx_count", 64'(rx_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk("rx_order", {32'd0, rx_q[i]}, {32'd0, exp_q[i]});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
